vid_in_timing_recover: RTL and testbench
========================================

# vid_in_timing_recover

Input-side counterpart to the video output stencil. It accepts raw hs/vs/de/RGB from a DVI/HDMI receiver and regenerates clean hde/vde enables, pixel coordinates and measured frame geometry. It also reports a lock status so downstream pixel-pipe stages can trust the recovered timing. Sits at the head of the capture pixel pipe, one pixel tick ahead of the first processing stage.

## Interface
Parameters:
- RGB_hbit, 1, MSB index of each colour port ([RGB_hbit:0]).
- HS_invert, 0, 1 = incoming HS is active-low; normalised to active-high internally and on hs_out.
- VS_invert, 0, same for VS.
- CNT_BITS, 12, width of all counters and measurement outputs.
- LOCK_FRAMES, 2, consecutive identical frames required to assert locked (1..15).

Ports:
- pclk  in  1  pixel clock; single clock domain.
- reset  in  1  synchronous, active-high.
- pc_ena  in  4  pixel clock enable; a pixel tick is pc_ena==0. All state updates only on ticks.
- hs_in, vs_in, de_in  in  1 each  raw receiver sync and data enable.
- r_in, g_in, b_in  in  RGB_hbit+1 each  raw pixel data.
- hs_out, vs_out  out  1 each  normalised active-high syncs, delayed 1 tick.
- hde_out, vde_out  out  1 each  recovered display enables.
- r_out, g_out, b_out  out  RGB_hbit+1  data delayed 1 tick, muted to 0 when de_in low.
- x_pos, y_pos  out  CNT_BITS  coordinate of the pixel on r/g/b_out.
- h_total, h_active, v_total, v_active  out  CNT_BITS  latched measurements.
- locked  out  1  timing stable.
- fmt_change  out  1  one-tick pulse on loss of lock from LOCKED.

## Operation
- Normalise: hs_n = hs_in ^ HS_invert, vs_n = vs_in ^ VS_invert. Leading edge = 0→1 of hs_n/vs_n versus the previous tick's registered value. de edges are detected the same way.
- Pass-through: hs_out, vs_out, hde_out = de_in, and r/g/b are registered on each tick.
- x_pos: 0 on the tick de rises; +1 per tick while de high; holds when de low.
- y_pos: on de rise, 0 if first_line flag set (flag set by vs leading edge, cleared by de rise); else y_pos+1.
- vde_out:
  - Set on de rise.
  - Cleared on vs leading edge.
  - Cleared on an hs leading edge that ends a line containing no de-high tick.
- h_total: tick counter restarts at 1 on hs leading edge; latched on the next hs leading edge.
- h_active: run length of de high, latched on de fall.
- v_total: hs leading edges counted from one vs leading edge to the next.
  - An hs edge coincident with a vs edge belongs to the new frame.
  - Latched on vs leading edge.
- v_active: de-rise count within the frame, latched on vs leading edge.
- All counters saturate at all-ones; no wrap.
- Lock FSM, evaluated on vs leading edge (frame end):
  - SEARCH: first vs leading edge → MEASURE, match_cnt=0; measurements of that partial frame are discarded.
  - MEASURE: new {h_total,h_active,v_total,v_active} equals previous frame → match_cnt+1, else match_cnt=1. Reaching LOCK_FRAMES → LOCKED, locked=1.
  - LOCKED: any mismatch → MEASURE, match_cnt=1, locked=0, fmt_change=1 for one tick.
  - Watchdog: from any state, 2^CNT_BITS−1 ticks with no hs leading edge → SEARCH, locked=0. fmt_change pulses only if leaving LOCKED.
- Measurement outputs update every frame regardless of lock.

## Timing
- Latency: 1 pixel tick from inputs to hs/vs/hde/rgb outputs. x_pos/y_pos are aligned with r/g/b_out.
- vde_out rises with hde_out on the first active pixel. vde_out falls 1 tick after the qualifying hs/vs edge.
- locked rises 1 tick after the vs leading edge that completes the LOCK_FRAMES-th match. fmt_change is coincident with locked falling.
- Reset (any cycle, including mid-frame): every output is 0. FSM=SEARCH, counters and flags cleared, first_line=1. Takes effect on the next pclk edge regardless of pc_ena.
- Non-tick cycles: all outputs hold.
- Simultaneous de rise and hs edge: the line count increments, then y_pos updates; both apply in the same tick.

## Test plan
- Ideal timing (h_total=20, h_active=12, v_total=10, v_active=6, pc_ena tied 0), 4 frames:
  - measurements read 20/12/10/6;
  - locked rises after the 3rd vs edge (SEARCH, then 2 matches);
  - x_pos spans 0..11 and y_pos spans 0..5 aligned with hde_out.
- HS_invert=VS_invert=1 with active-low syncs → identical results; hs_out/vs_out active-high.
- Locked, then h_active changed to 10 → fmt_change pulses once at next vs edge, locked=0; re-locks 2 frames later with h_active=10.
- Syncs stopped for 4095 ticks while locked → SEARCH, locked=0, fmt_change one pulse; resuming syncs re-locks after 3 vs edges.
- pc_ena cycling 0..3 → all outputs change only on pc_ena==0 ticks; results match the first scenario.
- Reset asserted mid-line while locked → next cycle all outputs 0 and FSM SEARCH; de_in-high pixels after reset output muted RGB=0 only when de_in low.

Source files
------------

// File: rtl/vid_in_timing_recover.sv
// Input-side video timing recovery: normalises receiver syncs, regenerates
// horizontal/vertical display enables and pixel coordinates, measures the
// incoming frame geometry and tracks whether that geometry is stable.
module vid_in_timing_recover #(
  parameter int RGB_hbit    = 1,
  parameter int HS_invert   = 0,
  parameter int VS_invert   = 0,
  parameter int CNT_BITS    = 12,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                pclk,
  input  logic                reset,
  input  logic [3:0]          pc_ena,
  input  logic                hs_in,
  input  logic                vs_in,
  input  logic                de_in,
  input  logic [RGB_hbit:0]   r_in,
  input  logic [RGB_hbit:0]   g_in,
  input  logic [RGB_hbit:0]   b_in,
  output logic                hs_out,
  output logic                vs_out,
  output logic                hde_out,
  output logic                vde_out,
  output logic [RGB_hbit:0]   r_out,
  output logic [RGB_hbit:0]   g_out,
  output logic [RGB_hbit:0]   b_out,
  output logic [CNT_BITS-1:0] x_pos,
  output logic [CNT_BITS-1:0] y_pos,
  output logic [CNT_BITS-1:0] h_total,
  output logic [CNT_BITS-1:0] h_active,
  output logic [CNT_BITS-1:0] v_total,
  output logic [CNT_BITS-1:0] v_active,
  output logic                locked,
  output logic                fmt_change
);

  localparam logic                HS_INV = (HS_invert != 0);
  localparam logic                VS_INV = (VS_invert != 0);
  localparam logic [CNT_BITS-1:0] CMAX   = '1;
  localparam logic [CNT_BITS-1:0] CONE   = CNT_BITS'(1);
  localparam logic [3:0]          LOCK_N = 4'(LOCK_FRAMES);
  localparam int                  MW     = 4 * CNT_BITS;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == CMAX) ? v : v + CONE;
  endfunction

  logic                tick;
  logic                hs_n, vs_n;
  logic                hs_rise, vs_rise, de_rise, de_fall;
  logic                wd_timeout;
  logic [MW-1:0]       meas_new;

  logic                hs_q, hs_d, vs_q, vs_d, hde_q, hde_d, vde_q, vde_d;
  logic [RGB_hbit:0]   r_q, r_d, g_q, g_d, b_q, b_d;
  logic [CNT_BITS-1:0] x_q, x_d, y_q, y_d;
  logic                first_line_q, first_line_d, line_de_q, line_de_d;
  logic [CNT_BITS-1:0] hcnt_q, hcnt_d, hrun_q, hrun_d, vcnt_q, vcnt_d;
  logic [CNT_BITS-1:0] vact_q, vact_d, wd_q, wd_d;
  logic [CNT_BITS-1:0] h_total_q, h_total_d, h_active_q, h_active_d;
  logic [CNT_BITS-1:0] v_total_q, v_total_d, v_active_q, v_active_d;
  state_t              state_q, state_d;
  logic [3:0]          match_q, match_d;
  logic [MW-1:0]       prev_q, prev_d;
  logic                prev_vld_q, prev_vld_d;
  logic                locked_q, locked_d, fmt_q, fmt_d;

  // Edges are taken against the previous tick's registered (normalised) levels.
  assign tick    = (pc_ena == 4'd0);
  assign hs_n    = hs_in ^ HS_INV;
  assign vs_n    = vs_in ^ VS_INV;
  assign hs_rise = hs_n & ~hs_q;
  assign vs_rise = vs_n & ~vs_q;
  assign de_rise = de_in & ~hde_q;
  assign de_fall = ~de_in & hde_q;
  assign wd_timeout = tick && !hs_rise && (wd_q == (CMAX - CONE));

  // Pass-through, coordinates, enables and geometry counters.
  always_comb begin
    hs_d = hs_q;  vs_d = vs_q;  hde_d = hde_q;  vde_d = vde_q;
    r_d = r_q;  g_d = g_q;  b_d = b_q;
    x_d = x_q;  y_d = y_q;
    first_line_d = first_line_q;  line_de_d = line_de_q;
    hcnt_d = hcnt_q;  hrun_d = hrun_q;  vcnt_d = vcnt_q;  vact_d = vact_q;  wd_d = wd_q;
    h_total_d = h_total_q;  h_active_d = h_active_q;
    v_total_d = v_total_q;  v_active_d = v_active_q;
    if (tick) begin
      hs_d  = hs_n;
      vs_d  = vs_n;
      hde_d = de_in;
      r_d   = de_in ? r_in : '0;
      g_d   = de_in ? g_in : '0;
      b_d   = de_in ? b_in : '0;

      if (de_rise)    x_d = '0;
      else if (de_in) x_d = sat_inc(x_q);

      if (de_rise) y_d = (first_line_q || vs_rise) ? '0 : sat_inc(y_q);

      if (vs_rise)      first_line_d = 1'b1;
      else if (de_rise) first_line_d = 1'b0;

      // A line with no active pixel closes the vertical active region.
      if (vs_rise)                      vde_d = 1'b0;
      else if (de_rise)                 vde_d = 1'b1;
      else if (hs_rise && !line_de_q)   vde_d = 1'b0;

      if (hs_rise)    line_de_d = de_in;
      else if (de_in) line_de_d = 1'b1;

      if (hs_rise) begin
        hcnt_d    = CONE;
        h_total_d = hcnt_q;
      end else begin
        hcnt_d    = sat_inc(hcnt_q);
      end

      if (de_rise)    hrun_d = CONE;
      else if (de_in) hrun_d = sat_inc(hrun_q);
      if (de_fall)    h_active_d = hrun_q;

      // An hs edge on the same tick as the vs edge opens the new frame.
      if (vs_rise) begin
        v_total_d  = vcnt_q;
        v_active_d = vact_q;
        vcnt_d     = hs_rise ? CONE : '0;
        vact_d     = de_rise ? CONE : '0;
      end else begin
        if (hs_rise) vcnt_d = sat_inc(vcnt_q);
        if (de_rise) vact_d = sat_inc(vact_q);
      end

      wd_d = hs_rise ? '0 : sat_inc(wd_q);
    end
  end

  // Lock tracking: compare each completed frame's geometry with the previous one.
  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    fmt_d      = fmt_q;
    meas_new   = {h_total_d, h_active_d, v_total_d, v_active_d};
    if (tick) begin
      fmt_d = 1'b0;
      if (wd_timeout) begin
        state_d    = SEARCH;
        match_d    = 4'd0;
        prev_vld_d = 1'b0;
        fmt_d      = (state_q == LOCKED);
      end else if (vs_rise) begin
        prev_d     = meas_new;
        prev_vld_d = 1'b1;
        case (state_q)
          SEARCH: begin
            // The frame that was in progress when searching began is partial.
            state_d    = MEASURE;
            match_d    = 4'd0;
            prev_vld_d = 1'b0;
          end
          MEASURE: begin
            if (prev_vld_q && (meas_new == prev_q))
              match_d = (match_q == 4'hF) ? match_q : match_q + 4'd1;
            else
              match_d = 4'd1;
            if (match_d >= LOCK_N) state_d = LOCKED;
          end
          LOCKED: begin
            if (meas_new != prev_q) begin
              state_d = MEASURE;
              match_d = 4'd1;
              fmt_d   = 1'b1;
            end
          end
          default: state_d = SEARCH;
        endcase
      end
    end
    locked_d = (state_d == LOCKED);
  end

  // State register; reset wins over the clock enable.
  always_ff @(posedge pclk) begin
    if (reset) begin
      hs_q <= 1'b0;  vs_q <= 1'b0;  hde_q <= 1'b0;  vde_q <= 1'b0;
      r_q <= '0;  g_q <= '0;  b_q <= '0;
      x_q <= '0;  y_q <= '0;
      first_line_q <= 1'b1;  line_de_q <= 1'b0;
      hcnt_q <= '0;  hrun_q <= '0;  vcnt_q <= '0;  vact_q <= '0;  wd_q <= '0;
      h_total_q <= '0;  h_active_q <= '0;  v_total_q <= '0;  v_active_q <= '0;
      state_q <= SEARCH;  match_q <= 4'd0;  prev_q <= '0;  prev_vld_q <= 1'b0;
      locked_q <= 1'b0;  fmt_q <= 1'b0;
    end else begin
      hs_q <= hs_d;  vs_q <= vs_d;  hde_q <= hde_d;  vde_q <= vde_d;
      r_q <= r_d;  g_q <= g_d;  b_q <= b_d;
      x_q <= x_d;  y_q <= y_d;
      first_line_q <= first_line_d;  line_de_q <= line_de_d;
      hcnt_q <= hcnt_d;  hrun_q <= hrun_d;  vcnt_q <= vcnt_d;  vact_q <= vact_d;  wd_q <= wd_d;
      h_total_q <= h_total_d;  h_active_q <= h_active_d;
      v_total_q <= v_total_d;  v_active_q <= v_active_d;
      state_q <= state_d;  match_q <= match_d;  prev_q <= prev_d;  prev_vld_q <= prev_vld_d;
      locked_q <= locked_d;  fmt_q <= fmt_d;
    end
  end

  assign hs_out     = hs_q;
  assign vs_out     = vs_q;
  assign hde_out    = hde_q;
  assign vde_out    = vde_q;
  assign r_out      = r_q;
  assign g_out      = g_q;
  assign b_out      = b_q;
  assign x_pos      = x_q;
  assign y_pos      = y_q;
  assign h_total    = h_total_q;
  assign h_active   = h_active_q;
  assign v_total    = v_total_q;
  assign v_active   = v_active_q;
  assign locked     = locked_q;
  assign fmt_change = fmt_q;

endmodule

// File: tb/tb_vid_in_timing_recover.sv
// Bench for vid_in_timing_recover: two instances (normal and inverted syncs)
// share one directed video stream; a monitor checks every pixel tick against
// a scoreboard filled by the stimulus, and directed checks cover lock events.
module tb_vid_in_timing_recover;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, mon_en, s_vde;
  logic [3:0] pc_ena;
  logic       hs_drv, vs_drv, de_in;
  logic [7:0] r_in, g_in, b_in;
  logic       hs_neg, vs_neg;
  assign hs_neg = ~hs_drv;
  assign vs_neg = ~vs_drv;

  logic        hs0, vs0, hde0, vde0, lk0, fc0, hs1, vs1, hde1, vde1, lk1, fc1;
  logic [7:0]  r0, g0, b0, r1, g1, b1;
  logic [11:0] x0, y0, ht0, ha0, vt0, va0, x1, y1, ht1, ha1, vt1, va1;

  vid_in_timing_recover #(.RGB_hbit(7), .HS_invert(0), .VS_invert(0), .CNT_BITS(12), .LOCK_FRAMES(2)) u0 (
    .pclk(clk), .reset(reset), .pc_ena(pc_ena), .hs_in(hs_drv), .vs_in(vs_drv), .de_in(de_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .hs_out(hs0), .vs_out(vs0), .hde_out(hde0), .vde_out(vde0),
    .r_out(r0), .g_out(g0), .b_out(b0), .x_pos(x0), .y_pos(y0), .h_total(ht0), .h_active(ha0),
    .v_total(vt0), .v_active(va0), .locked(lk0), .fmt_change(fc0));

  vid_in_timing_recover #(.RGB_hbit(7), .HS_invert(1), .VS_invert(1), .CNT_BITS(12), .LOCK_FRAMES(2)) u1 (
    .pclk(clk), .reset(reset), .pc_ena(pc_ena), .hs_in(hs_neg), .vs_in(vs_neg), .de_in(de_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .hs_out(hs1), .vs_out(vs1), .hde_out(hde1), .vde_out(vde1),
    .r_out(r1), .g_out(g1), .b_out(b1), .x_pos(x1), .y_pos(y1), .h_total(ht1), .h_active(ha1),
    .v_total(vt1), .v_active(va1), .locked(lk1), .fmt_change(fc1));

  logic [101:0] all0, all1, last0, last1;
  assign all0 = {hs0, vs0, hde0, vde0, r0, g0, b0, x0, y0, ht0, ha0, vt0, va0, lk0, fc0};
  assign all1 = {hs1, vs1, hde1, vde1, r1, g1, b1, x1, y1, ht1, ha1, vt1, va1, lk1, fc1};

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } pix_t;

  pix_t q[$];
  pix_t p;
  int   tests = 0, fails = 0;
  int   fc_cnt0 = 0, fc_cnt1 = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Capture what the DUT should have registered on this edge.
  logic tick_s = 1'b0, rst_s = 1'b1, mon_s = 1'b0;
  logic e_hs = 1'b0, e_vs = 1'b0, e_de = 1'b0, e_vde = 1'b0;
  always @(posedge clk) begin
    tick_s <= (pc_ena == 4'd0) && !reset;
    rst_s  <= reset;
    mon_s  <= mon_en;
    e_hs   <= hs_drv;
    e_vs   <= vs_drv;
    e_de   <= de_in;
    e_vde  <= s_vde;
  end

  // Monitor: checks every registered output half a cycle after the edge.
  always @(negedge clk) begin
    if (mon_s) begin
      if (tick_s) begin
        chk("ctl0", {hs0, vs0, hde0, vde0}, {e_hs, e_vs, e_de, e_vde});
        chk("ctl1", {hs1, vs1, hde1, vde1}, {e_hs, e_vs, e_de, e_vde});
        if (e_de) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pix_queue: pixel seen at x=%0d y=%0d but none expected", x0, y0);
          end else begin
            p = q.pop_front();
            chk("pix0", {x0, y0, r0, g0, b0}, p);
            chk("pix1", {x1, y1, r1, g1, b1}, p);
          end
        end else begin
          chk("mute", {r0, g0, b0, r1, g1, b1}, 48'd0);
        end
        if (fc0) begin fc_cnt0++; chk("fmt_lock0", lk0, 0); end
        if (fc1) begin fc_cnt1++; chk("fmt_lock1", lk1, 0); end
      end else if (!rst_s) begin
        chk("hold", {all0, all1}, {last0, last1});
      end
    end
    last0 = all0;
    last1 = all1;
  end

  task automatic drive(input logic hs, input logic vs, input logic de,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input int cyc);
    hs_drv = hs; vs_drv = vs; de_in = de; r_in = r; g_in = g; b_in = b;
    for (int c = 0; c < cyc; c++) begin
      pc_ena = 4'(c);
      @(posedge clk);
      #1;
    end
  endtask

  // 20x10 frame: hs on ticks 0-1, vs rises on line 1 with hs, active lines 3..8 from tick 4.
  task automatic frame(input int hact, input int cyc);
    pix_t e;
    logic de;
    for (int l = 0; l < 10; l++) begin
      for (int c = 0; c < 20; c++) begin
        de = (l >= 3) && (l <= 8) && (c >= 4) && (c < 4 + hact);
        if (l == 0 && c == 0) s_vde = 1'b0;
        if (l == 3 && c == 4) s_vde = 1'b1;
        if (de) begin
          e.x = 12'(c - 4);
          e.y = 12'(l - 3);
          e.r = 8'(c * 3 + l);
          e.g = 8'(c) ^ 8'hF0;
          e.b = 8'(l * 16 + c);
          q.push_back(e);
          drive(c < 2, (l == 1) || (l == 2), 1'b1, e.r, e.g, e.b, cyc);
        end else begin
          drive(c < 2, (l == 1) || (l == 2), 1'b0, 8'hAA, 8'h55, 8'hFF, cyc);
        end
      end
    end
  endtask

  task automatic chk_meas(input int ha);
    chk("h_total0", ht0, 20);  chk("h_active0", ha0, ha);
    chk("v_total0", vt0, 10);  chk("v_active0", va0, 6);
    chk("h_total1", ht1, 20);  chk("h_active1", ha1, ha);
    chk("v_total1", vt1, 10);  chk("v_active1", va1, 6);
  endtask

  task automatic chk_lock(input string name, input logic exp);
    chk(name, {lk0, lk1}, {exp, exp});
  endtask

  initial begin
    reset = 1'b1; mon_en = 1'b0; s_vde = 1'b0; pc_ena = 4'd0;
    hs_drv = 1'b0; vs_drv = 1'b0; de_in = 1'b0; r_in = 8'h0; g_in = 8'h0; b_in = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset0", all0, 0);
    chk("reset1", all1, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Ideal timing, every cycle a tick.
    frame(12, 1);
    chk_lock("lock_f1", 1'b0);
    frame(12, 1);
    chk_meas(12);
    chk_lock("lock_f2", 1'b0);
    frame(12, 1);
    chk_lock("lock_f3", 1'b1);
    frame(12, 1);
    chk_lock("lock_f4", 1'b1);

    // Format change: narrower active line.
    frame(10, 1);
    chk_lock("lock_f5", 1'b1);
    chk("fmt_none", fc_cnt0, 0);
    frame(10, 1);
    chk_lock("lock_f6", 1'b0);
    chk("fmt_once0", fc_cnt0, 1);
    chk("fmt_once1", fc_cnt1, 1);
    chk_meas(10);
    frame(10, 1);
    chk_lock("relock_f7", 1'b1);

    // Sync loss: watchdog must not fire early, then must drop lock.
    repeat (4000) drive(1'b0, 1'b0, 1'b0, 8'h11, 8'h22, 8'h33, 1);
    chk_lock("wd_early", 1'b1);
    repeat (200) drive(1'b0, 1'b0, 1'b0, 8'h11, 8'h22, 8'h33, 1);
    chk_lock("wd_drop", 1'b0);
    chk("wd_fmt0", fc_cnt0, 2);
    chk("wd_fmt1", fc_cnt1, 2);
    frame(12, 1);
    chk_lock("wd_f1", 1'b0);
    frame(12, 1);
    chk_lock("wd_f2", 1'b0);
    frame(12, 1);
    chk_lock("wd_f3", 1'b1);
    chk_meas(12);

    // Reset between frames, then pixel clock enable cycling 0..3.
    mon_en = 1'b0;
    reset = 1'b1;
    pc_ena = 4'd3;
    @(posedge clk);
    #1;
    chk("reset_cyc", {all0, all1}, 204'd0);
    reset = 1'b0;
    q.delete();
    s_vde = 1'b0;
    mon_en = 1'b1;
    frame(12, 4);
    frame(12, 4);
    chk_meas(12);
    chk_lock("cyc_f2", 1'b0);
    frame(12, 4);
    chk_lock("cyc_f3", 1'b1);
    frame(12, 4);
    chk_lock("cyc_f4", 1'b1);
    chk("cyc_no_fmt", fc_cnt0, 2);
    @(negedge clk);
    chk("queue_empty", q.size(), 0);

    // Reset mid-line while locked.
    mon_en = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 8'h12, 8'h34, 8'h56, 1);
    drive(1'b0, 1'b0, 1'b1, 8'h13, 8'h35, 8'h57, 1);
    chk("pre_rst", {hde0, lk0, hde1, lk1}, 4'hF);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 8'h9A, 8'hBC, 8'hDE, 1);
    chk("mid_rst", {all0, all1}, 204'd0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 8'h5A, 8'hA5, 8'h3C, 1);
    chk("post_rst_pix0", {hde0, lk0, x0, y0, r0, g0, b0}, {1'b1, 1'b0, 12'd0, 12'd0, 8'h5A, 8'hA5, 8'h3C});
    chk("post_rst_pix1", {hde1, lk1, x1, y1, r1, g1, b1}, {1'b1, 1'b0, 12'd0, 12'd0, 8'h5A, 8'hA5, 8'h3C});
    drive(1'b0, 1'b0, 1'b1, 8'h01, 8'h02, 8'h03, 1);
    chk("post_rst_x", {x0, r0, g0, b0}, {12'd1, 8'h01, 8'h02, 8'h03});
    drive(1'b0, 1'b0, 1'b0, 8'h77, 8'h77, 8'h77, 1);
    chk("post_rst_mute", {hde0, r0, g0, b0, hde1, r1, g1, b1}, 50'd0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
